// File: rtl/cola_fifo_ctrl.sv
// Pointer, flag and read-register controller for a 16-entry queue held in an
// external dual-port distributed RAM (synchronous write, asynchronous read).
module cola_fifo_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_req,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_address_w,
    output logic [ADDR_W-1:0] mem_address_r,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);
    localparam int PTR_W = ADDR_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              push_acc, pop_acc;
    logic              full_w, empty_w;

    // Extra wrap bit on each pointer separates full from empty when the
    // RAM addresses coincide. Status depends on registered pointers only.
    assign empty_w = (wr_ptr_q == rd_ptr_q);
    assign full_w  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                     (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);

    always_comb begin
        push_acc     = wr_req && !full_w && !rst;
        pop_acc      = rd_req && !empty_w;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        dout_d       = dout_q;
        dout_valid_d = pop_acc;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;
        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            dout_d   = mem_data_out;
        end
        if (wr_req && full_w) begin
            overflow_d = 1'b1;
        end
        if (rd_req && empty_w) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    assign dout          = dout_q;
    assign dout_valid    = dout_valid_q;
    assign full          = full_w;
    assign empty         = empty_w;
    assign count         = wr_ptr_q - rd_ptr_q;
    assign overflow      = overflow_q;
    assign underflow     = underflow_q;
    assign mem_wr_en     = push_acc;
    assign mem_address_w = wr_ptr_q[ADDR_W-1:0];
    assign mem_address_r = rd_ptr_q[ADDR_W-1:0];
    assign mem_data_in   = din;

endmodule

// File: doc/cola_fifo_ctrl.md
# cola_fifo_ctrl

Pointer, flag and read-register controller for the 16-entry queue. It drives the write port, address buses and write enable of the 16x3 dual-port distributed RAM, and consumes that RAM's asynchronous read-port output. It presents a synchronous push/pop FIFO interface to the rest of the design, with full/empty/count status and sticky error flags.

## Interface
- ADDR_W, 4, RAM address width; depth = 2**ADDR_W = 16
- DATA_W, 3, word width; matches RAM data width

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous reset, active-high
- wr_req  in  1  push request
- din  in  DATA_W  push data
- rd_req  in  1  pop request
- dout  out  DATA_W  registered pop data
- dout_valid  out  1  one-cycle pulse: dout updated this cycle
- full  out  1  count == 16
- empty  out  1  count == 0
- count  out  ADDR_W+1  occupancy, 0..16
- overflow  out  1  sticky: push attempted while full
- underflow  out  1  sticky: pop attempted while empty
- mem_wr_en  out  1  to RAM WE
- mem_address_w  out  ADDR_W  to RAM write/SPO address (A3..A0)
- mem_address_r  out  ADDR_W  to RAM DPRA3..DPRA0
- mem_data_in  out  DATA_W  to RAM D
- mem_data_out  in  DATA_W  from RAM DPO (asynchronous read of mem_address_r)

## Operation
- State: wr_ptr, rd_ptr, each ADDR_W+1 bits (MSB = wrap bit); dout, dout_valid, overflow, underflow registers.
- count = wr_ptr - rd_ptr, modulo 2**(ADDR_W+1). empty = (wr_ptr == rd_ptr). full = (addresses equal, wrap bits differ). All status is decoded from registered pointers only; no combinational path from wr_req/rd_req to full/empty/count.
- Push accepted: wr_req && !full && !rst. mem_wr_en = push accepted (combinational). mem_address_w = wr_ptr[ADDR_W-1:0]. mem_data_in = din. On edge: wr_ptr += 1.
- Pop accepted: rd_req && !empty. mem_address_r = rd_ptr[ADDR_W-1:0]. On edge: dout <= mem_data_out, rd_ptr += 1, dout_valid <= 1. Otherwise dout holds and dout_valid <= 0.
- Simultaneous push and pop, neither full nor empty: both accepted; count unchanged.
- Push while full: rejected, even if a pop is accepted in the same cycle; overflow <= 1; pointers and RAM untouched.
- Pop while empty: rejected, even if a push is accepted in the same cycle; underflow <= 1; dout holds; dout_valid <= 0.
- Pointer wrap: address 15 -> 0 toggles the wrap bit. The 5-bit compare makes full and empty unambiguous.
- overflow/underflow are cleared only by rst.

## Timing
- Reset values (asserted asynchronously, held while rst = 1): wr_ptr = rd_ptr = 0, count = 0, empty = 1, full = 0, dout = 0, dout_valid = 0, overflow = 0, underflow = 0, mem_wr_en = 0, both addresses 0.
- Reset mid-operation: queue empties immediately. RAM contents are not cleared but are unreachable. No write occurs in a cycle where rst is high.
- Write-to-read latency: a word pushed at edge N makes empty = 0 after edge N. A pop may be requested in cycle N+1, and dout/dout_valid present the word after edge N+1.
- Pop latency: 1 cycle, request cycle to registered dout.
- Back-to-back pops at 1 word/clock with no bubbles. Back-to-back pushes at 1 word/clock.
- full asserts after the 16th accepted push edge. empty asserts after the edge consuming the last word.

## Test plan
- Reset then idle: after rst release, empty = 1, full = 0, count = 0, dout = 0, no mem_wr_en pulse.
- Fill and drain: push 16 words 0,1,..,7,0,..,7 on consecutive cycles. Required: full = 1 and count = 16 after the 16th edge. Then pop 16: dout sequence identical, dout_valid high for 16 consecutive cycles, empty = 1 at the end.
- Overflow/underflow: on full, push 3'b101 -> overflow = 1, count stays 16, next pops return the original data. Drain, then pop -> underflow = 1, dout unchanged, dout_valid = 0.
- Wrap-around: push 10 words, pop 10, then push 10 more (write addresses 10..15, 0..3). Pop all -> data order preserved, count peaks at 10, full never asserts.
- Simultaneous push/pop: with count = 5, assert both for 20 cycles with incrementing data. Required: count stays 5, output order equals input order, no flags set. With count = 16, push+pop -> pop accepted, push rejected, overflow = 1, count = 15.
- Async reset mid-stream: with count = 7, assert rst between edges. Required: outputs take reset values immediately, without waiting for a clock edge. After release, the first push/pop returns the newly pushed word, not stale data.
